// File: rtl/adder_arb_pkg.sv
// ----------------------------------------------------------------------------
// adder_arb_pkg
// Shared definitions for the round-robin shared-adder arbiter:
//   - state_e    : FSM state encoding (IDLE / EXEC / RESP)
//   - DEF_W      : default operand / sum width
//   - DEF_NREQ   : default number of requesters
//   - clog2()    : ceiling log2 used to derive the requester-ID width
// ----------------------------------------------------------------------------
package adder_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int DEF_W    = 4;
  localparam int DEF_NREQ = 4;

  // Ceiling log2 with a floor of 1, so a 1-bit ID is still produced for n <= 2.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: selects the first set bit of req searching
// upward from ptr, wrapping back to bit 0.
// Ports:
//   req   [NREQ-1:0]  request vector
//   ptr   [IDW-1:0]   index with highest priority this cycle (< NREQ)
//   grant [NREQ-1:0]  one-hot grant (all zero when nothing requested)
//   idx   [IDW-1:0]   index of the granted bit
//   any               at least one request present
// ----------------------------------------------------------------------------
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  // Two passes with constant indices: the first covers bits at or above ptr,
  // the second (reached only if the first found nothing) takes the lowest set
  // bit, which must then lie below ptr -- this is the wrap-around.
  always_comb begin
    // NOTE: every output gets a default before any conditional assignment,
    // otherwise paths that skip an assignment would infer latches.
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any && req[i] && (IDW'(i) >= ptr)) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        idx      = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!any && req[i]) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        idx      = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/adder_share_arb.sv
// ----------------------------------------------------------------------------
// adder_share_arb
// Shares one W-bit adder among NREQ requesters with round-robin arbitration.
// A grant in IDLE latches the winner's operands, EXEC registers the sum, and
// RESP holds the tagged result until the consumer takes it.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid [NREQ]        per-requester operands pending
//   req_a/req_b [NREQ*W]    flattened operands, slice i = [i*W +: W]
//   req_ready [NREQ]        one-hot accept pulse (IDLE only)
//   rsp_valid/rsp_ready     response handshake
//   rsp_sum [W]             (a+b) mod 2^W
//   rsp_id [IDW]            requester that owns the result
//   busy                    high in any state other than IDLE
// Build option:
//   ADDER_ARB_CARRY_EN      adds output rsp_carry, the registered carry-out
// ----------------------------------------------------------------------------
module adder_share_arb
  import adder_arb_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0] req_ready,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [W-1:0]    rsp_sum,
  output logic [IDW-1:0]  rsp_id,
  output logic            busy
`ifdef ADDER_ARB_CARRY_EN
  ,
  output logic            rsp_carry
`endif
);

  state_e          r_state;
  state_e          w_next_state;
  logic [IDW-1:0]  r_rr_ptr;
  logic [W-1:0]    r_op_a;
  logic [W-1:0]    r_op_b;
  logic [IDW-1:0]  r_op_id;
  logic [W-1:0]    r_sum;
  logic [IDW-1:0]  r_rsp_id;
`ifdef ADDER_ARB_CARRY_EN
  logic            r_carry;
`endif

  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_idx;
  logic            w_any;
  logic [W-1:0]    w_sel_a;
  logic [W-1:0]    w_sel_b;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (r_rr_ptr),
    .grant (w_grant),
    .idx   (w_idx),
    .any   (w_any)
  );

  // Operand mux driven by the one-hot grant.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_a = req_a[i*W +: W];
        w_sel_b = req_b[i*W +: W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next state and handshake outputs.
  always_comb begin
    w_next_state = r_state;
    req_ready    = '0;
    rsp_valid    = 1'b0;
    busy         = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        // The grant is combinational, so it must be masked while reset is
        // held: the state flop sits in IDLE then but nothing is accepted.
        if (rst_n) req_ready = w_grant;
        if (w_any) w_next_state = ST_EXEC;
      end
      ST_EXEC: w_next_state = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Operand capture, adder and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operand and result registers are few and observable on the
      // response port, so they are all cleared to give defined outputs.
      r_rr_ptr <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_op_id  <= '0;
      r_sum    <= '0;
      r_rsp_id <= '0;
`ifdef ADDER_ARB_CARRY_EN
      r_carry  <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_op_a  <= w_sel_a;
            r_op_b  <= w_sel_b;
            r_op_id <= w_idx;
          end
        end
        ST_EXEC: begin
`ifdef ADDER_ARB_CARRY_EN
          {r_carry, r_sum} <= {1'b0, r_op_a} + {1'b0, r_op_b};
`else
          r_sum <= r_op_a + r_op_b;
`endif
          r_rsp_id <= r_op_id;
          // Winner gets lowest priority next time.
          if (r_op_id == IDW'(NREQ - 1)) r_rr_ptr <= '0;
          else                           r_rr_ptr <= r_op_id + IDW'(1);
        end
        default: ;
      endcase
    end
  end

  assign rsp_sum = r_sum;
  assign rsp_id  = r_rsp_id;
`ifdef ADDER_ARB_CARRY_EN
  assign rsp_carry = r_carry;
`endif

endmodule

// File: tb/tb_adder_share_arb.sv
// ----------------------------------------------------------------------------
// tb_adder_share_arb
// Directed bench for adder_share_arb (W=4, NREQ=4): reset, round-robin
// fairness, single request latency, wrap-around sum, response backpressure
// and reset in the middle of an operation.
// ----------------------------------------------------------------------------
module tb_adder_share_arb;

  localparam int W    = 4;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic            clk;
  logic            rst_n;
  logic [NREQ-1:0] req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0] req_ready;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [W-1:0]    rsp_sum;
  logic [IDW-1:0]  rsp_id;
  logic            busy;
`ifdef ADDER_ARB_CARRY_EN
  logic            rsp_carry;
`endif

  int n_cmp = 0;
  int n_err = 0;

  adder_share_arb #(
    .W    (W),
    .NREQ (NREQ),
    .IDW  (IDW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .busy      (busy)
`ifdef ADDER_ARB_CARRY_EN
    ,
    .rsp_carry (rsp_carry)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  // Expected sums for requester i with a=i+1, b=2i+3.
  logic [W-1:0] fair_sum [NREQ] = '{4'd4, 4'd7, 4'd10, 4'd13};

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < NREQ; i++) set_op(i, W'(i + 1), W'(2 * i + 3));

    // Reset held with every requester valid.
    @(negedge clk); #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_sum",   32'(rsp_sum),   32'h0);
    check("rst_rsp_id",    32'(rsp_id),    32'h0);
    check("rst_busy",      32'(busy),      32'h0);

    // Fairness: grants 0,1,2,3,0,1, one every three cycles.
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("fair_grant", 32'(req_ready), 32'(1 << (k % NREQ)));
      @(negedge clk); #1;
      check("fair_exec_ready", 32'(req_ready), 32'h0);
      check("fair_exec_busy",  32'(busy),      32'h1);
      check("fair_exec_valid", 32'(rsp_valid), 32'h0);
      @(negedge clk); #1;
      check("fair_rsp_valid", 32'(rsp_valid), 32'h1);
      check("fair_rsp_sum",   32'(rsp_sum),   32'(fair_sum[k % NREQ]));
      check("fair_rsp_id",    32'(rsp_id),    32'(k % NREQ));
      if (k == 5) req_valid = '0;
      @(negedge clk);
    end

    // Idle with nothing pending; pointer now at 2.
    #1;
    check("idle_ready", 32'(req_ready), 32'h0);
    check("idle_busy",  32'(busy),      32'h0);

    // Single request from requester 2: 3+5=8, result at T+2.
    req_valid = 4'b0100;
    set_op(2, 4'd3, 4'd5);
    #1;
    check("single_grant", 32'(req_ready), 32'h4);
    @(negedge clk);
    req_valid = '0;
    #1;
    check("single_t1_valid", 32'(rsp_valid), 32'h0);
    @(negedge clk); #1;
    check("single_t2_valid", 32'(rsp_valid), 32'h1);
    check("single_sum",      32'(rsp_sum),   32'h8);
    check("single_id",       32'(rsp_id),    32'h2);

    // Wrap-around from requester 3: 9+9 = 18 -> 2, carry out set.
    @(negedge clk);
    req_valid = 4'b1000;
    set_op(3, 4'd9, 4'd9);
    #1;
    check("wrap_grant", 32'(req_ready), 32'h8);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk); #1;
    check("wrap_sum", 32'(rsp_sum), 32'h2);
    check("wrap_id",  32'(rsp_id),  32'h3);
`ifdef ADDER_ARB_CARRY_EN
    check("wrap_carry", 32'(rsp_carry), 32'h1);
`endif

    // Backpressure: requester 0 (7+6=13) held in RESP while requester 1 waits.
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    set_op(0, 4'd7, 4'd6);
    #1;
    check("bp_grant0", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 4'b0010;
    set_op(1, 4'd2, 4'd2);
    #1;
    check("bp_exec_ready", 32'(req_ready), 32'h0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      check("bp_hold_valid", 32'(rsp_valid), 32'h1);
      check("bp_hold_sum",   32'(rsp_sum),   32'hd);
      check("bp_hold_id",    32'(rsp_id),    32'h0);
      check("bp_hold_ready", 32'(req_ready), 32'h0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    check("bp_release_valid", 32'(rsp_valid), 32'h1);
    check("bp_release_ready", 32'(req_ready), 32'h0);
    @(negedge clk); #1;
    check("bp_grant1",     32'(req_ready), 32'h2);
    check("bp_idle_valid", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk); #1;
    check("bp_req1_sum", 32'(rsp_sum), 32'h4);
    check("bp_req1_id",  32'(rsp_id),  32'h1);

    // Reset during EXEC: pointer was 2, afterwards lowest valid index wins.
    @(negedge clk);
    req_valid = 4'b0110;
    set_op(2, 4'd1, 4'd1);
    #1;
    check("mid_grant", 32'(req_ready), 32'h4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 32'h0);
    check("mid_rst_busy",  32'(busy),      32'h0);
    check("mid_rst_ready", 32'(req_ready), 32'h0);
    @(negedge clk); #1;
    check("mid_rst_valid2", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_post_grant", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk); #1;
    check("mid_post_valid", 32'(rsp_valid), 32'h1);
    check("mid_post_sum",   32'(rsp_sum),   32'h4);
    check("mid_post_id",    32'(rsp_id),    32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
